// File: rtl/ram_arb_2rq_if.sv
// Requester A/B command and response channels plus the single-port RAM port.
// The arbiter connects as slave; clients and the RAM model connect as master.
interface ram_arb_2rq_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
);
   logic              a_valid;
   logic              a_ready;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_w_data;
   logic              a_rsp_valid;
   logic [DATA_W-1:0] a_rsp_data;

   logic              b_valid;
   logic              b_ready;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_w_data;
   logic              b_rsp_valid;
   logic [DATA_W-1:0] b_rsp_data;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_w_data;
   logic [DATA_W-1:0] ram_r_data;

   modport slave (
      input  a_valid, a_we, a_addr, a_w_data,
      output a_ready, a_rsp_valid, a_rsp_data,
      input  b_valid, b_we, b_addr, b_w_data,
      output b_ready, b_rsp_valid, b_rsp_data,
      output ram_we, ram_addr, ram_w_data,
      input  ram_r_data
   );

   modport master (
      output a_valid, a_we, a_addr, a_w_data,
      input  a_ready, a_rsp_valid, a_rsp_data,
      output b_valid, b_we, b_addr, b_w_data,
      input  b_ready, b_rsp_valid, b_rsp_data,
      input  ram_we, ram_addr, ram_w_data,
      output ram_r_data
   );
endinterface

// File: rtl/ram_arb_2rq.sv
// Two-requester round-robin arbiter sequencing one single-port, synchronous-read RAM.
// Grants are combinational; read data is routed back to its requester one cycle later.
module ram_arb_2rq #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   ram_arb_2rq_if.slave bus
);
   logic              r_prio;
   logic [1:0]        r_rsp;
   logic              w_gnt_a;
   logic              w_gnt_b;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_w_data;

   // Preference only matters under contention; reset suppresses every grant.
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (!rst) begin
         if (bus.a_valid && (!bus.b_valid || !r_prio)) begin
            w_gnt_a = 1'b1;
         end else if (bus.b_valid) begin
            w_gnt_b = 1'b1;
         end
      end
   end

   // RAM port follows the granted requester and idles at zero otherwise.
   always_comb begin
      w_ram_we     = 1'b0;
      w_ram_addr   = ADDR_W'(0);
      w_ram_w_data = DATA_W'(0);
      if (w_gnt_a) begin
         w_ram_we     = bus.a_we;
         w_ram_addr   = bus.a_addr;
         w_ram_w_data = bus.a_w_data;
      end else if (w_gnt_b) begin
         w_ram_we     = bus.b_we;
         w_ram_addr   = bus.b_addr;
         w_ram_w_data = bus.b_w_data;
      end
   end

   // Priority flips away from the last winner; response bits mark accepted reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio <= 1'b0;
         r_rsp  <= 2'b00;
      end else begin
         if (w_gnt_a) begin
            r_prio <= 1'b1;
         end else if (w_gnt_b) begin
            r_prio <= 1'b0;
         end
         r_rsp <= {w_gnt_b & ~bus.b_we, w_gnt_a & ~bus.a_we};
      end
   end

   assign bus.a_ready     = w_gnt_a;
   assign bus.b_ready     = w_gnt_b;
   assign bus.ram_we      = w_ram_we;
   assign bus.ram_addr    = w_ram_addr;
   assign bus.ram_w_data  = w_ram_w_data;
   assign bus.a_rsp_valid = r_rsp[0];
   assign bus.b_rsp_valid = r_rsp[1];
   assign bus.a_rsp_data  = r_rsp[0] ? bus.ram_r_data : DATA_W'(0);
   assign bus.b_rsp_data  = r_rsp[1] ? bus.ram_r_data : DATA_W'(0);

   a_one_grant: assert property (@(posedge clk) disable iff (rst) !(bus.a_ready && bus.b_ready));
endmodule

// File: tb/tb_ram_arb_2rq.sv
// Scoreboard bench for ram_arb_2rq: a reference memory predicts read data on each expected
// acceptance, and a negedge monitor pops and compares every response pulse.
module tb_ram_arb_2rq;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic clk = 1'b0;
   logic rst;

   ram_arb_2rq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram_arb_2rq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read single-port RAM, old data on read-during-write.
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_w_data;
      bus.ram_r_data <= mem[bus.ram_addr];
   end

   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] exp_a [$];
   logic [DATA_W-1:0] exp_b [$];
   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;

   task automatic set_a(input logic v, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] d);
      bus.a_valid = v; bus.a_we = we; bus.a_addr = addr; bus.a_w_data = d;
   endtask

   task automatic set_b(input logic v, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] d);
      bus.b_valid = v; bus.b_we = we; bus.b_addr = addr; bus.b_w_data = d;
   endtask

   task automatic accept_a(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
      if (we) ref_mem[addr] = d;
      else    exp_a.push_back(ref_mem[addr]);
   endtask

   task automatic accept_b(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
      if (we) ref_mem[addr] = d;
      else    exp_b.push_back(ref_mem[addr]);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every pulse must match the oldest outstanding read for that requester.
   always @(negedge clk) begin : mon
      logic [DATA_W-1:0] e;
      if (mon_en) begin
         n_checks++;
         if (bus.a_rsp_valid === 1'b1) begin
            if (exp_a.size() == 0) begin
               $display("FAIL a_rsp_unexpected: got data %h with no read outstanding", bus.a_rsp_data);
            end else begin
               e = exp_a.pop_front();
               if (bus.a_rsp_data !== e) $display("FAIL a_rsp_data: got %h want %h", bus.a_rsp_data, e);
               else n_pass++;
            end
         end else if (bus.a_rsp_valid !== 1'b0 || bus.a_rsp_data !== 16'h0) begin
            $display("FAIL a_rsp_idle: got valid %b data %h want 0/0000", bus.a_rsp_valid, bus.a_rsp_data);
         end else n_pass++;

         n_checks++;
         if (bus.b_rsp_valid === 1'b1) begin
            if (exp_b.size() == 0) begin
               $display("FAIL b_rsp_unexpected: got data %h with no read outstanding", bus.b_rsp_data);
            end else begin
               e = exp_b.pop_front();
               if (bus.b_rsp_data !== e) $display("FAIL b_rsp_data: got %h want %h", bus.b_rsp_data, e);
               else n_pass++;
            end
         end else if (bus.b_rsp_valid !== 1'b0 || bus.b_rsp_data !== 16'h0) begin
            $display("FAIL b_rsp_idle: got valid %b data %h want 0/0000", bus.b_rsp_valid, bus.b_rsp_data);
         end else n_pass++;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      set_a(1'b1, 1'b0, 4'd0, 16'h0);
      set_b(1'b1, 1'b0, 4'd0, 16'h0);
      next_cycle();
      mon_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.a_ready, bus.b_ready, bus.ram_we, bus.a_rsp_valid, bus.b_rsp_valid} !== 5'b0)
            $display("FAIL reset_outputs: got rdy %b%b we %b rsp %b%b want all 0", bus.a_ready,
                     bus.b_ready, bus.ram_we, bus.a_rsp_valid, bus.b_rsp_valid);
         else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_first_grant();
      rst = 1'b0;
      set_a(1'b1, 1'b1, 4'd1, 16'h0011);
      set_b(1'b1, 1'b1, 4'd2, 16'h0022);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready, bus.ram_we, bus.ram_addr, bus.ram_w_data} !== {2'b10, 1'b1, 4'd1, 16'h0011})
         $display("FAIL first_grant: got rdy %b%b we %b addr %h data %h want 10 1 1 0011",
                  bus.a_ready, bus.b_ready, bus.ram_we, bus.ram_addr, bus.ram_w_data);
      else n_pass++;
      accept_a(1'b1, 4'd1, 16'h0011);
      next_cycle();
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready, bus.ram_we, bus.ram_addr, bus.ram_w_data} !== {2'b01, 1'b1, 4'd2, 16'h0022})
         $display("FAIL second_grant_b: got rdy %b%b we %b addr %h data %h want 01 1 2 0022",
                  bus.a_ready, bus.b_ready, bus.ram_we, bus.ram_addr, bus.ram_w_data);
      else n_pass++;
      accept_b(1'b1, 4'd2, 16'h0022);
      next_cycle();
      set_b(1'b0, 1'b0, 4'd0, 16'h0);
   endtask

   task automatic test_contention();
      logic [1:0] exp_rdy;
      logic [1:0] exp_rsp;
      set_a(1'b1, 1'b0, 4'd1, 16'h0);
      set_b(1'b1, 1'b0, 4'd2, 16'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
         n_checks++;
         if ({bus.a_ready, bus.b_ready} !== exp_rdy)
            $display("FAIL contention_grant[%0d]: got %b%b want %b", k, bus.a_ready, bus.b_ready, exp_rdy);
         else n_pass++;
         if (k > 0) begin
            exp_rsp = (k % 2 == 1) ? 2'b10 : 2'b01;
            n_checks++;
            if ({bus.a_rsp_valid, bus.b_rsp_valid} !== exp_rsp)
               $display("FAIL contention_rsp[%0d]: got %b%b want %b", k, bus.a_rsp_valid,
                        bus.b_rsp_valid, exp_rsp);
            else n_pass++;
         end
         if (k % 2 == 0) accept_a(1'b0, 4'd1, 16'h0);
         else            accept_b(1'b0, 4'd2, 16'h0);
         next_cycle();
      end
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      set_b(1'b0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b01)
         $display("FAIL contention_last_rsp: got %b%b want 01", bus.a_rsp_valid, bus.b_rsp_valid);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_single();
      set_a(1'b1, 1'b1, 4'd3, 16'hBEEF);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready, bus.ram_we} !== 3'b101)
         $display("FAIL single_write: got rdy %b%b we %b want 10 1", bus.a_ready, bus.b_ready, bus.ram_we);
      else n_pass++;
      accept_a(1'b1, 4'd3, 16'hBEEF);
      next_cycle();
      set_a(1'b1, 1'b0, 4'd3, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b0, 4'd3})
         $display("FAIL single_read: got rdy %b we %b addr %h want 1 0 3", bus.a_ready, bus.ram_we, bus.ram_addr);
      else n_pass++;
      accept_a(1'b0, 4'd3, 16'h0);
      next_cycle();
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_rsp_valid, bus.b_rsp_valid, bus.ram_we, bus.a_rsp_data} !== {3'b100, 16'hBEEF})
         $display("FAIL single_rsp: got rsp %b%b we %b data %h want 10 0 beef", bus.a_rsp_valid,
                  bus.b_rsp_valid, bus.ram_we, bus.a_rsp_data);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_fairness();
      set_a(1'b1, 1'b0, 4'd1, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL fair_lone_a: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      accept_a(1'b0, 4'd1, 16'h0);
      next_cycle();
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready, bus.ram_we, bus.ram_addr, bus.ram_w_data} !== 23'h0)
         $display("FAIL fair_idle: got rdy %b%b we %b addr %h data %h want all 0", bus.a_ready,
                  bus.b_ready, bus.ram_we, bus.ram_addr, bus.ram_w_data);
      else n_pass++;
      next_cycle();
      set_a(1'b1, 1'b0, 4'd1, 16'h0);
      set_b(1'b1, 1'b0, 4'd2, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b01)
         $display("FAIL fair_b_first: got %b%b want 01", bus.a_ready, bus.b_ready);
      else n_pass++;
      accept_b(1'b0, 4'd2, 16'h0);
      next_cycle();
      set_b(1'b0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL fair_a_next: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      accept_a(1'b0, 4'd1, 16'h0);
      next_cycle();
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
   endtask

   task automatic test_mixed();
      set_a(1'b1, 1'b1, 4'd7, 16'h0777);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL mixed_preload: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      accept_a(1'b1, 4'd7, 16'h0777);
      next_cycle();
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      set_b(1'b1, 1'b0, 4'd2, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b01)
         $display("FAIL mixed_prio_b: got %b%b want 01", bus.a_ready, bus.b_ready);
      else n_pass++;
      accept_b(1'b0, 4'd2, 16'h0);
      next_cycle();
      set_a(1'b1, 1'b0, 4'd7, 16'h0);
      set_b(1'b1, 1'b1, 4'd7, 16'h1234);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready, bus.ram_we} !== 3'b100)
         $display("FAIL mixed_a_first: got rdy %b%b we %b want 10 0", bus.a_ready, bus.b_ready, bus.ram_we);
      else n_pass++;
      accept_a(1'b0, 4'd7, 16'h0);
      next_cycle();
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready, bus.ram_we, bus.ram_w_data} !== {3'b011, 16'h1234})
         $display("FAIL mixed_b_write: got rdy %b%b we %b data %h want 01 1 1234", bus.a_ready,
                  bus.b_ready, bus.ram_we, bus.ram_w_data);
      else n_pass++;
      accept_b(1'b1, 4'd7, 16'h1234);
      next_cycle();
      set_b(1'b0, 1'b0, 4'd0, 16'h0);
      set_a(1'b1, 1'b0, 4'd7, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_rsp_valid} !== 2'b10)
         $display("FAIL mixed_write_no_rsp: got a_ready %b b_rsp_valid %b want 1 0", bus.a_ready, bus.b_rsp_valid);
      else n_pass++;
      accept_a(1'b0, 4'd7, 16'h0);
      next_cycle();
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_rsp_valid, bus.a_rsp_data} !== {1'b1, 16'h1234})
         $display("FAIL mixed_reread: got valid %b data %h want 1 1234", bus.a_rsp_valid, bus.a_rsp_data);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_reset_mid();
      set_a(1'b1, 1'b0, 4'd3, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL rmid_accept: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      accept_a(1'b0, 4'd3, 16'h0);
      next_cycle();
      rst = 1'b1;
      set_a(1'b1, 1'b0, 4'd1, 16'h0);
      set_b(1'b1, 1'b0, 4'd2, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready, bus.ram_we, bus.a_rsp_valid, bus.b_rsp_valid, bus.a_rsp_data}
          !== {5'b00010, 16'hBEEF})
         $display("FAIL rmid_rsp_survives: got rdy %b%b we %b rsp %b%b data %h want 00 0 10 beef",
                  bus.a_ready, bus.b_ready, bus.ram_we, bus.a_rsp_valid, bus.b_rsp_valid, bus.a_rsp_data);
      else n_pass++;
      next_cycle();
      rst = 1'b0;
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      set_b(1'b0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00)
         $display("FAIL rmid_no_rsp: got %b%b want 00", bus.a_rsp_valid, bus.b_rsp_valid);
      else n_pass++;
      next_cycle();
      set_a(1'b1, 1'b0, 4'd1, 16'h0);
      set_b(1'b1, 1'b0, 4'd2, 16'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL rmid_first_grant_a: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      accept_a(1'b0, 4'd1, 16'h0);
      next_cycle();
      set_a(1'b0, 1'b0, 4'd0, 16'h0);
      set_b(1'b0, 1'b0, 4'd0, 16'h0);
      next_cycle();
      next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_first_grant();
      test_contention();
      test_single();
      test_fairness();
      test_mixed();
      test_reset_mid();
      n_checks++;
      if (exp_a.size() != 0 || exp_b.size() != 0)
         $display("FAIL scoreboard_drain: got %0d/%0d reads outstanding want 0/0", exp_a.size(), exp_b.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
